// File: rtl/data_memory_hs_if.sv
// Request/response bus for data_memory_hs: one outstanding load or store at a time.
interface data_memory_hs_if #(
  parameter int unsigned ADDR_WIDTH = 32
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [31:0]           resp_rdata;
  logic                  resp_err;

  // Requester side (datapath MEM stage)
  modport master (
    output req_valid,
    output req_write,
    output req_size,
    output req_unsigned,
    output req_addr,
    output req_wdata,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err
  );

  // Memory side
  modport slave (
    input  req_valid,
    input  req_write,
    input  req_size,
    input  req_unsigned,
    input  req_addr,
    input  req_wdata,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err
  );

endinterface

// File: rtl/data_memory_hs.sv
// Synchronous word-organised data memory with valid/ready handshake, byte/half/word
// accesses, load extension, programmable wait states and access-error reporting.
module data_memory_hs #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  data_memory_hs_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = 4;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [31:0]         mem_q [DEPTH_WORDS];

  logic [ADDR_WIDTH-1:0] addr;
  logic [IdxW-1:0]       word_idx;
  logic [1:0]            lane;
  logic                  accept;
  logic                  acc_err;
  logic                  wr_en;
  logic [3:0]            be;
  logic [31:0]           wr_data;
  logic [31:0]           rd_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_data;

  assign addr     = bus.req_addr;
  assign word_idx = addr[IdxW+1:2];
  assign lane     = addr[1:0];

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign accept = bus.req_valid & bus.req_ready;

  // Reject reserved size, misalignment and any address beyond the array (no wrapping).
  always_comb begin
    acc_err = 1'b0;
    case (bus.req_size)
      2'b00:   acc_err = 1'b0;
      2'b01:   acc_err = lane[0];
      2'b10:   acc_err = (lane != 2'b00);
      default: acc_err = 1'b1;
    endcase
    if ((addr >> (IdxW + 2)) != '0) begin
      acc_err = 1'b1;
    end
  end

  // Store lane enables; data is replicated so every enabled lane sees its byte.
  always_comb begin
    be      = 4'b0000;
    wr_data = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        be      = 4'b0001 << lane;
        wr_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{bus.req_wdata[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  assign wr_en = accept & bus.req_write & ~acc_err;

  // Load lane extraction and sign/zero extension of the addressed word.
  assign rd_word = mem_q[word_idx];
  always_comb begin
    ld_byte = rd_word[{lane, 3'b000} +: 8];
    ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (bus.req_size)
      2'b00:   ld_data = bus.req_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = bus.req_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  // Storage array: commits stores on the accept edge; deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Next state, wait counter and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          err_d   = acc_err;
          rdata_d = (acc_err || bus.req_write) ? 32'h0 : ld_data;
          if (WAIT_CYCLES > 0) begin
            state_d = StWait;
            cnt_d   = CntW'(WAIT_CYCLES - 1);
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and response registers; a reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule
